instr_decode_stage: RTL and testbench

Decode stage sitting directly downstream of the fetch/instruction-memory stage of the 8-bit processor. Buffers fetched 16-bit instructions in a 2-entry queue, decodes them into registered control/field bundles, and applies valid/ready handshakes on both sides. Handles flush on taken branch/jump and inserts a one-cycle bubble on load-use hazards toward the execute stage.

---
 rtl/isa_pkg.sv | 117 +++++++++++
 rtl/instr_queue.sv | 58 +++++
 rtl/instr_decode_stage.sv | 109 ++++++++++
 tb/tb_instr_decode_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// ISA constants and decode helpers for the 8-bit processor's 16-bit instruction set.
// Shared by the decode stage; widths of pc and the output immediate live in the top.
package isa_pkg;

  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int RD_MSB    = 11;
  localparam int RD_LSB    = 9;
  localparam int RS_MSB    = 8;
  localparam int RS_LSB    = 6;
  localparam int RT_MSB    = 5;
  localparam int RT_LSB    = 3;
  localparam int FUNCT_MSB = 2;
  localparam int FUNCT_LSB = 0;
  localparam int IMM6_MSB  = 5;
  localparam int IMM8_MSB  = 7;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_BEQI  = 4'b1000;
  localparam logic [3:0] OP_LW    = 4'b1011;
  localparam logic [3:0] OP_SW    = 4'b1111;

  localparam logic [2:0] FUNCT_ILLEGAL = 3'b110;
  localparam logic [2:0] FUNCT_BEQ     = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_EOR = 3'd4,
    ALU_BIC = 3'd5
  } alu_op_t;

  // imm is already sign-extended to 8 bits; the stage widens it to IMM_W
  typedef struct packed {
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm;
    alu_op_t    alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } dec_t;

  function automatic dec_t decode(input logic [15:0] instr);
    dec_t       d;
    logic [3:0] opc;
    logic [2:0] funct;
    logic [7:0] sext6;
    opc   = instr[OPC_MSB:OPC_LSB];
    funct = instr[FUNCT_MSB:FUNCT_LSB];
    sext6 = {{2{instr[IMM6_MSB]}}, instr[IMM6_MSB:0]};
    d     = '0;
    d.rd  = instr[RD_MSB:RD_LSB];
    d.rs  = instr[RS_MSB:RS_LSB];
    case (opc)
      OP_RTYPE: begin
        d.rt = instr[RT_MSB:RT_LSB];
        case (funct)
          3'd0: begin d.alu_op = ALU_ADD; d.reg_write = 1'b1; end
          3'd1: begin d.alu_op = ALU_SUB; d.reg_write = 1'b1; end
          3'd2: begin d.alu_op = ALU_AND; d.reg_write = 1'b1; end
          3'd3: begin d.alu_op = ALU_OR;  d.reg_write = 1'b1; end
          3'd4: begin d.alu_op = ALU_EOR; d.reg_write = 1'b1; end
          3'd5: begin d.alu_op = ALU_BIC; d.reg_write = 1'b1; end
          FUNCT_BEQ: begin d.alu_op = ALU_SUB; d.branch = 1'b1; end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        d.reg_write = 1'b1;
        d.imm       = sext6;
      end
      OP_LW: begin
        d.mem_read  = 1'b1;
        d.reg_write = 1'b1;
        d.imm       = sext6;
      end
      OP_SW: begin
        d.mem_write = 1'b1;
        d.imm       = sext6;
        d.rt        = instr[RD_MSB:RD_LSB];
      end
      OP_BEQI: begin
        d.branch = 1'b1;
        d.alu_op = ALU_SUB;
        d.imm    = sext6;
        d.rt     = instr[RD_MSB:RD_LSB];
      end
      OP_JMP: begin
        d.jump = 1'b1;
        d.imm  = instr[IMM8_MSB:0];
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // True when instr sources register r (rs always, rt only where rt is a real source)
  function automatic logic reads_reg(input logic [15:0] instr, input logic [2:0] r);
    logic [3:0] opc;
    logic       uses_rt;
    logic [2:0] rt_src;
    opc     = instr[OPC_MSB:OPC_LSB];
    uses_rt = (opc == OP_RTYPE) || (opc == OP_SW) || (opc == OP_BEQI);
    rt_src  = (opc == OP_RTYPE) ? instr[RT_MSB:RT_LSB] : instr[RD_MSB:RD_LSB];
    return (instr[RS_MSB:RS_LSB] == r) || (uses_rt && (rt_src == r));
  endfunction

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO holding {instr, pc} pairs between fetch and decode.
// Flush empties it at the next edge and takes priority over a same-cycle write.
module instr_queue #(
  parameter int DATA_W = 22,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: queues fetched instructions, decodes into a registered bundle,
// handshakes on both sides, flushes on redirect and bubbles once on load-use.
module instr_decode_stage
  import isa_pkg::*;
#(
  parameter int PC_W    = 6,
  parameter int IMM_W   = 8,
  parameter int Q_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [15:0]      if_instr,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_ready,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [PC_W-1:0]  id_pc,
  output logic [2:0]       id_rd,
  output logic [2:0]       id_rs,
  output logic [2:0]       id_rt,
  output logic [IMM_W-1:0] id_imm,
  output logic [2:0]       id_alu_op,
  output logic             id_reg_write,
  output logic             id_mem_read,
  output logic             id_mem_write,
  output logic             id_branch,
  output logic             id_jump,
  output logic             id_illegal
);

  logic                 q_full;
  logic                 q_empty;
  logic                 q_wr;
  logic                 q_rd;
  logic [16+PC_W-1:0]   q_rd_data;
  logic [15:0]          head_instr;
  logic [PC_W-1:0]      head_pc;

  logic                 out_valid;
  logic [PC_W-1:0]      out_pc;
  dec_t                 out_dec;

  logic                 out_free;
  logic                 hazard;

  assign if_ready = !q_full;
  assign q_wr     = if_valid && if_ready;

  instr_queue #(
    .DATA_W (16 + PC_W),
    .DEPTH  (Q_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (q_wr),
    .wr_data ({if_instr, if_pc}),
    .rd_en   (q_rd),
    .rd_data (q_rd_data),
    .full    (q_full),
    .empty   (q_empty)
  );

  assign head_instr = q_rd_data[16+PC_W-1:PC_W];
  assign head_pc    = q_rd_data[PC_W-1:0];

  // mem_read is set only for LW, so it doubles as the load marker
  assign out_free = !out_valid || id_ready;
  assign hazard   = out_valid && out_dec.mem_read && id_ready && !q_empty
                    && reads_reg(head_instr, out_dec.rd);
  assign q_rd     = out_free && !q_empty && !hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_dec   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_dec   <= '0;
    end else if (q_rd) begin
      out_valid <= 1'b1;
      out_pc    <= head_pc;
      out_dec   <= decode(head_instr);
    end else if (out_free) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_dec   <= '0;
    end
  end

  assign id_valid     = out_valid;
  assign id_pc        = out_pc;
  assign id_rd        = out_dec.rd;
  assign id_rs        = out_dec.rs;
  assign id_rt        = out_dec.rt;
  assign id_imm       = IMM_W'($signed(out_dec.imm));
  assign id_alu_op    = out_dec.alu_op;
  assign id_reg_write = out_dec.reg_write;
  assign id_mem_read  = out_dec.mem_read;
  assign id_mem_write = out_dec.mem_write;
  assign id_branch    = out_dec.branch;
  assign id_jump      = out_dec.jump;
  assign id_illegal   = out_dec.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage: driver pushes expected bundles for
// accepted instructions, a negedge monitor pops and compares on each transfer.
module tb_instr_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [5:0]  if_pc;
  logic        if_ready;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  id_pc;
  logic [2:0]  id_rd, id_rs, id_rt;
  logic [7:0]  id_imm;
  logic [2:0]  id_alu_op;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal;

  instr_decode_stage #(.PC_W(6), .IMM_W(8), .Q_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .if_ready     (if_ready),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_rd        (id_rd),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_imm       (id_imm),
    .id_alu_op    (id_alu_op),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
    .id_jump      (id_jump),
    .id_illegal   (id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  int          log_cycle[$];
  logic [5:0]  pc_ctr = '0;
  logic        pend_flush = 1'b0;
  logic        acc_d;

  wire [31:0] act = {id_pc, id_rd, id_rs, id_rt, id_imm, id_alu_op,
                     id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_illegal};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: bundle {pc,rd,rs,rt,imm,alu,rw,mr,mw,br,j,ill} from the ISA table
  function automatic logic [31:0] model(input logic [15:0] ins, input logic [5:0] pc);
    int   op, f, rt, imm, alu, sx;
    logic rw, mr, mw, br, j, ill;
    op = ins[15:12]; f = ins[2:0];
    sx = ins[5:0]; if (sx >= 32) sx = sx - 64;
    rt = 0; imm = 0; alu = 0;
    {rw, mr, mw, br, j, ill} = 6'b0;
    if (op == 0) begin
      rt = ins[5:3];
      if (f <= 5) begin alu = f; rw = 1; end
      else if (f == 7) begin alu = 1; br = 1; end
      else ill = 1;
    end else if (op == 4)  begin rw = 1; imm = sx; end
    else if (op == 11) begin mr = 1; rw = 1; imm = sx; end
    else if (op == 15) begin mw = 1; imm = sx; rt = ins[11:9]; end
    else if (op == 8)  begin br = 1; alu = 1; imm = sx; rt = ins[11:9]; end
    else if (op == 2)  begin j = 1; imm = ins[7:0]; end
    else ill = 1;
    return {pc, ins[11:9], ins[8:6], 3'(rt), 8'(imm), 3'(alu), rw, mr, mw, br, j, ill};
  endfunction

  // Called at posedge+1; sets inputs for one cycle and books the expected result
  task automatic drive(input logic v, input logic [15:0] ins, input logic fl,
                       input logic rdy, output logic acc);
    if (pend_flush) exp_q.delete();
    if_valid = v; if_instr = ins; if_pc = pc_ctr; flush = fl; id_ready = rdy;
    acc = v && if_ready && !fl;
    if (acc) exp_q.push_back(model(ins, pc_ctr));
    if (v) pc_ctr++;
    pend_flush = fl;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 1'b0, rdy, acc_d);
  endtask

  task automatic load_use(input logic [15:0] consumer, input int gap_exp, input string name);
    int n0;
    drive(1'b1, 16'hB6C1, 1'b0, 1'b0, acc_d);
    drive(1'b1, consumer, 1'b0, 1'b0, acc_d);
    idle(1, 1'b0);
    n0 = log_cycle.size();
    idle(6, 1'b1);
    check({name, "_count"}, 64'(log_cycle.size()), 64'(n0 + 2));
    if (log_cycle.size() == n0 + 2)
      check({name, "_gap"}, 64'(log_cycle[n0+1] - log_cycle[n0]), 64'(gap_exp));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] ops [8] = '{4'h0, 4'h4, 4'hB, 4'hF, 4'h8, 4'h2, 4'h5, 4'h0};
    logic [3:0] op;
    op = ops[$urandom_range(0, 7)];
    return {op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 6'($urandom)};
  endfunction

  // Monitor: compare on every transfer, and hold stability under back-pressure
  initial begin
    logic [31:0] prev = '0;
    logic        hold = 1'b0;
    logic        prev_fl = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold = 1'b0; prev_fl = 1'b0;
      end else begin
        if (hold && !prev_fl) check("hold", {31'b0, id_valid, act}, {31'b0, 1'b1, prev});
        if (id_valid && id_ready) begin
          log_cycle.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_output: got %h expected none (t=%0t)", act, $time);
          end else begin
            check("bundle", 64'(act), 64'(exp_q.pop_front()));
          end
        end
        hold = id_valid && !id_ready;
        prev = act;
        prev_fl = flush;
      end
    end
  end

  initial begin
    int acc_n, n0, k;
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(id_valid), 64'd0);
    check("reset_outs", 64'(act), 64'd0);
    check("reset_if_ready", 64'(if_ready), 64'd1);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // minimum latency
    drive(1'b1, 16'h0440, 1'b0, 1'b1, acc_d);
    drive(1'b0, 16'h0, 1'b0, 1'b1, acc_d);
    check("latency", {id_valid, id_rd, id_rs, id_rt, id_alu_op, id_reg_write},
          {1'b1, 3'd2, 3'd1, 3'd0, 3'd0, 1'b1});
    idle(2, 1'b1);

    // immediates
    drive(1'b1, 16'h4FCF, 1'b0, 1'b1, acc_d);
    drive(1'b1, 16'h4273, 1'b0, 1'b1, acc_d);
    drive(1'b1, 16'h2303, 1'b0, 1'b1, acc_d);
    idle(4, 1'b1);

    // back-pressure: one in output plus Q_DEPTH queued
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rand_instr(), 1'b0, 1'b0, acc_d);
      if (acc_d) acc_n++;
    end
    check("accept_count", 64'(acc_n), 64'd3);
    check("full_if_ready", 64'(if_ready), 64'd0);
    k = 0;
    while ((exp_q.size() != 0 || !if_ready) && k < 20) begin idle(1, 1'b1); k++; end
    check("drain_done", {62'b0, if_ready, exp_q.size() == 0}, 64'd3);

    // load-use hazards
    load_use(16'h08C0, 2, "lw_add_dep");
    load_use(16'h0940, 1, "lw_add_nodep");
    load_use(16'hF600, 2, "lw_sw_dep");

    // flush with valid output and full queue
    for (int i = 0; i < 3; i++) drive(1'b1, rand_instr(), 1'b0, 1'b0, acc_d);
    drive(1'b1, 16'h0440, 1'b1, 1'b0, acc_d);
    check("flush_full", {62'b0, id_valid, if_ready}, 64'd1);
    // flush while an offer is acceptable: that offer must vanish
    drive(1'b1, 16'h4111, 1'b0, 1'b0, acc_d);
    drive(1'b1, 16'h4222, 1'b0, 1'b0, acc_d);
    n0 = log_cycle.size();
    drive(1'b1, 16'h4333, 1'b1, 1'b0, acc_d);
    idle(5, 1'b1);
    check("flush_discard", 64'(log_cycle.size()), 64'(n0));

    // illegal encodings
    drive(1'b1, 16'h5ABC, 1'b0, 1'b1, acc_d);
    drive(1'b1, 16'h0006, 1'b0, 1'b1, acc_d);
    drive(1'b1, 16'hE123, 1'b0, 1'b1, acc_d);
    idle(4, 1'b1);

    // reset mid-stream with two queued and one valid output
    for (int i = 0; i < 3; i++) drive(1'b1, rand_instr(), 1'b0, 1'b0, acc_d);
    rst_n = 1'b0; if_valid = 1'b0;
    exp_q.delete(); pend_flush = 1'b0;
    #1;
    check("midreset_valid", 64'(id_valid), 64'd0);
    check("midreset_outs", 64'(act), 64'd0);
    check("midreset_if_ready", 64'(if_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = log_cycle.size();
    idle(5, 1'b1);
    check("post_reset_quiet", 64'(log_cycle.size()), 64'(n0));

    // randomized traffic
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0, acc_d);
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin idle(1, 1'b1); k++; end
    check("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
